// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a byte stream into little-endian
// 32-bit words, writes them to consecutive word addresses, then releases the CPU.
module imem_loader #(
   parameter int DEPTH = 100,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] word_count,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

   state_t           state_q, state_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [CNT_W-1:0] word_idx_q, word_idx_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             cpu_hold_q, cpu_hold_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;

   logic count_bad;
   logic byte_fire;
   logic last_word;

   assign count_bad = (word_count == '0) || (word_count > CNT_W'(DEPTH));
   assign byte_fire = rx_valid && (state_q == RECV);
   assign last_word = (word_idx_q == count_q - CNT_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         byte_cnt_q  <= '0;
         word_idx_q  <= '0;
         count_q     <= '0;
         cpu_hold_q  <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         word_idx_q  <= word_idx_d;
         count_q     <= count_d;
         cpu_hold_q  <= cpu_hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERR: if (start) state_d = count_bad ? ERR : RECV;
         RECV:            if (byte_fire && byte_cnt_q == 2'd3) state_d = WRITE;
         WRITE:           state_d = last_word ? DONE : RECV;
         default:         state_d = IDLE;
      endcase
   end

   // NOTE: every signal gets a hold default first so no path through this block infers a latch.
   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      word_idx_d  = word_idx_q;
      count_d     = count_q;
      cpu_hold_d  = cpu_hold_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = (state_d == WRITE);

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               cpu_hold_d = 1'b1;
               done_d     = 1'b0;
               if (count_bad) begin
                  err_d = 1'b1;
               end else begin
                  err_d      = 1'b0;
                  busy_d     = 1'b1;
                  word_idx_d = '0;
                  byte_cnt_d = '0;
                  count_d    = word_count;
               end
            end
         end
         RECV: begin
            if (byte_fire) begin
               mem_wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               // Address is registered alongside the strobe so both appear in the WRITE cycle.
               if (byte_cnt_q == 2'd3) mem_addr_d = 32'(word_idx_q) << 2;
            end
         end
         WRITE: begin
            if (last_word) begin
               busy_d     = 1'b0;
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
            end else begin
               word_idx_d = word_idx_q + CNT_W'(1);
               byte_cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   assign rx_ready  = (state_q == RECV);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a per-cycle behavioural model plus
// hand-computed expectations for each directed scenario.
module tb_imem_loader;

   localparam int DEPTH = 100;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] word_count;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             cpu_hold;
   logic             busy;
   logic             done;
   logic             err;

   int tests = 0;
   int fails = 0;

   imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .word_count(word_count),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what each output must be in the current cycle.
   bit          m_recv = 0, m_we = 0, m_busy = 0, m_done = 0, m_err = 0, m_hold = 1;
   int          m_widx = 0, m_cnt = 0, m_wc;
   logic [7:0]  m_bytes[$];
   logic [31:0] m_addr, m_data;
   logic [63:0] obs[$];   // {addr, data} of every write seen

   always @(negedge clk) begin
      check("rx_ready", 32'(rx_ready), 32'(m_recv));
      check("mem_we",   32'(mem_we),   32'(m_we));
      check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
      check("busy",     32'(busy),     32'(m_busy));
      check("done",     32'(done),     32'(m_done));
      check("err",      32'(err),      32'(m_err));
      if (m_we) begin
         check("mem_addr",  mem_addr,  m_addr);
         check("mem_wdata", mem_wdata, m_data);
      end
      if (mem_we) obs.push_back({mem_addr, mem_wdata});

      // Advance to the next cycle using the inputs now held stable.
      if (rst) begin
         m_recv = 0; m_we = 0; m_busy = 0; m_done = 0; m_err = 0; m_hold = 1;
         m_bytes.delete();
      end else if (m_we) begin
         m_we = 0;
         if (m_widx == m_cnt - 1) begin
            m_busy = 0; m_done = 1; m_hold = 0;
         end else begin
            m_widx++; m_recv = 1;
         end
      end else if (m_recv) begin
         if (rx_valid) begin
            m_bytes.push_back(rx_data);
            if (m_bytes.size() == 4) begin
               m_data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
               m_addr = 32'(m_widx * 4);
               m_we   = 1; m_recv = 0;
               m_bytes.delete();
            end
         end
      end else if (start) begin
         m_wc = int'(word_count);
         m_done = 0; m_hold = 1;
         if (m_wc == 0 || m_wc > DEPTH) begin
            m_err = 1;
         end else begin
            m_err = 0; m_recv = 1; m_busy = 1; m_widx = 0; m_cnt = m_wc;
            m_bytes.delete();
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input int wc);
      start = 1'b1;
      word_count = CNT_W'(wc);
      idle(1);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit taken = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 50 && !taken; i++) begin
         @(negedge clk);
         if (rx_ready) taken = 1;
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
      if (!taken) begin
         tests++; fails++;
         $display("FAIL byte_timeout: byte %h not accepted within 50 cycles", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      logic [31:0] v;
      v = w;
      for (int k = 0; k < 4; k++) begin
         send_byte(v[8*k +: 8]);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic check_two_words(input string tag);
      check({tag, "_nwrites"}, 32'(obs.size()), 32'd2);
      if (obs.size() >= 2) begin
         check({tag, "_addr0"}, obs[0][63:32], 32'h0000_0000);
         check({tag, "_data0"}, obs[0][31:0],  32'h2000_0013);
         check({tag, "_addr1"}, obs[1][63:32], 32'h0000_0004);
         check({tag, "_data1"}, obs[1][31:0],  32'hAC00_0008);
      end
      check({tag, "_done"}, 32'(done),     32'd1);
      check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; word_count = '0; rx_data = '0; rx_valid = 1'b0;
      idle(2);
      rst = 1'b0;

      // Reset then idle
      idle(4);
      check("rst_hold", 32'(cpu_hold), 32'd1);
      check("rst_busy", 32'(busy),     32'd0);
      check("rst_done", 32'(done),     32'd0);
      check("rst_err",  32'(err),      32'd0);
      check("rst_we",   32'(mem_we),   32'd0);
      check("rst_addr", mem_addr,      32'd0);
      check("rst_data", mem_wdata,     32'd0);
      check("rst_nwrites", 32'(obs.size()), 32'd0);

      // Two words at full rate
      obs.delete();
      do_start(2);
      send_word(32'h2000_0013, 0);
      send_word(32'hAC00_0008, 0);
      idle(3);
      check_two_words("full_rate");

      // Same load with gaps, plus a start pulse mid-load that must be ignored
      obs.delete();
      do_start(2);
      send_byte(8'h13); idle(2);
      start = 1'b1; word_count = CNT_W'(5); idle(1); start = 1'b0;
      check("gap_busy", 32'(busy), 32'd1);
      send_byte(8'h00); idle(2);
      send_byte(8'h00); idle(2);
      send_byte(8'h20); idle(2);
      send_word(32'hAC00_0008, 2);
      idle(3);
      check_two_words("gaps");

      // Illegal counts
      do_start(0);
      idle(2);
      check("cnt0_err",   32'(err),      32'd1);
      check("cnt0_hold",  32'(cpu_hold), 32'd1);
      check("cnt0_ready", 32'(rx_ready), 32'd0);
      check("cnt0_done",  32'(done),     32'd0);
      do_start(101);
      idle(2);
      check("cnt101_err",   32'(err),      32'd1);
      check("cnt101_hold",  32'(cpu_hold), 32'd1);
      check("cnt101_ready", 32'(rx_ready), 32'd0);
      obs.delete();
      do_start(1);
      check("legal_clears_err", 32'(err), 32'd0);
      send_word(32'h0000_0093, 0);
      idle(3);
      check("one_done",   32'(done), 32'd1);
      check("one_wdata",  obs.size() > 0 ? obs[0][31:0] : 32'hxxxx_xxxx, 32'h0000_0093);

      // Full-depth load
      obs.delete();
      do_start(DEPTH);
      for (int w = 0; w < DEPTH; w++) send_word(32'hC000_0000 | 32'(w), 0);
      idle(3);
      check("full_nwrites", 32'(obs.size()), 32'd100);
      if (obs.size() == 100) begin
         check("full_last_addr", obs[99][63:32], 32'h0000_018C);
         check("full_last_data", obs[99][31:0],  32'hC000_0063);
      end
      check("full_done", 32'(done),     32'd1);
      check("full_hold", 32'(cpu_hold), 32'd0);

      // Reset mid-word, and reset beating a simultaneous start
      obs.delete();
      do_start(1);
      send_byte(8'h55);
      send_byte(8'h66);
      rst = 1'b1; idle(1); rst = 1'b0;
      idle(3);
      check("midrst_nwrites", 32'(obs.size()), 32'd0);
      check("midrst_hold",    32'(cpu_hold),   32'd1);
      check("midrst_busy",    32'(busy),       32'd0);
      check("midrst_ready",   32'(rx_ready),   32'd0);
      rst = 1'b1; start = 1'b1; word_count = CNT_W'(1); idle(1);
      rst = 1'b0; start = 1'b0;
      idle(2);
      check("rst_start_busy", 32'(busy), 32'd0);
      do_start(1);
      send_word(32'hDEAD_BEEF, 0);
      idle(3);
      check("fresh_nwrites", 32'(obs.size()), 32'd1);
      if (obs.size() == 1) begin
         check("fresh_addr", obs[0][63:32], 32'h0000_0000);
         check("fresh_data", obs[0][31:0],  32'hDEAD_BEEF);
      end
      check("fresh_done", 32'(done), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader and sequencer for the instruction memory.
- Accepts a byte stream on a valid/ready handshake and assembles it into 32-bit little-endian words.
- Writes each word to consecutive word-aligned byte addresses, using the same PC-style byte addressing as the fetch path (memory indexes by address >> 2).
- Holds the processor in reset until a complete program is loaded, then releases it.

Parameters:
- DEPTH, 100, number of 32-bit words in instruction memory.
- CNT_W, 8, width of the word_count input; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load of word_count words.
- word_count  input  CNT_W  number of words to load; sampled when start is accepted.
- rx_data  input  8  program byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of the write; always a multiple of 4.
- mem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  high keeps the processor (PC register) in reset.
- busy  output  1  a load is in progress.
- done  output  1  the last load completed successfully; level signal.
- err  output  1  the last start had an illegal word_count; level signal.

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs, except rx_ready, which is decoded from state.
- Reset values:
  - state = IDLE.
  - cpu_hold = 1.
  - rx_ready, mem_we, busy, done, err = 0.
  - mem_addr, mem_wdata = 0.
  - Byte counter, word index and stored count = 0.
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE / DONE / ERR: on start, the loader samples word_count.
  - If word_count == 0 or word_count > DEPTH: go to ERR, err = 1, done = 0, cpu_hold = 1.
  - Otherwise: go to RECV, busy = 1, done = 0, err = 0, cpu_hold = 1, word index = 0, byte counter = 0.
- RECV: rx_ready = 1. A byte transfers only on a cycle where rx_valid && rx_ready.
  - Byte k (k = 0..3) lands in mem_wdata[8k+7:8k]; byte 0 is the least significant.
  - On the 4th byte, go to WRITE.
  - rx_valid low stalls the loader indefinitely; there is no timeout.
- WRITE: exactly one cycle, with rx_ready = 0, mem_we = 1, mem_addr = word_index << 2, and mem_wdata holding the complete word.
  - Latency: mem_we is asserted on the cycle immediately after the 4th byte handshake.
  - Next cycle, if word_index == stored_count − 1: go to DONE, busy = 0, done = 1, cpu_hold = 0.
  - Otherwise: word_index + 1, byte counter = 0, return to RECV.
- DONE: cpu_hold = 0; the processor runs. A new start re-asserts cpu_hold on the next cycle and reloads from address 0.
- ERR: cpu_hold stays 1; leave only via a legal start or rst.
- start while in RECV or WRITE is ignored. The stored count is not resampled.
- mem_addr wraps never: the legal-count check guarantees the last address is ≤ (DEPTH−1)*4.
- rst mid-load, in any state, takes effect on the next edge:
  - The partial word is discarded and no write is issued.
  - cpu_hold returns to 1.
  - Words already written stay in memory; the loader does not clear them.
- rst and start in the same cycle: rst wins; start is dropped.
- mem_we is never asserted outside WRITE. At most one write occurs per 5 cycles at full input rate.

Test Plan:
- Reset then idle: rst high for 2 cycles, then low → cpu_hold = 1, busy = done = err = 0, mem_we = 0; stays so with no start.
- Load 2 words: start with word_count = 2, then stream bytes 0x13,0x00,0x00,0x20 and 0x08,0x00,0x00,0xAC with rx_valid continuously high → exactly two mem_we pulses:
  - 1st: addr 0x0, data 0x20000013.
  - 2nd: addr 0x4, data 0xAC000008.
  - Then done = 1 and cpu_hold = 0 on the cycle after the 2nd write.
- Backpressure/gaps: same 2-word load with rx_valid toggling 1,0,0,1,… → identical writes and data; no extra or missing strobes; busy stays 1 throughout.
- Illegal counts:
  - start with word_count = 0 → err = 1, cpu_hold = 1, rx_ready stays 0.
  - start with word_count = 101 (DEPTH = 100) → same result.
  - A subsequent start with word_count = 1 clears err.
- Full-depth load: word_count = 100 with incrementing words → last write at mem_addr 0x18C (396), then done = 1 and cpu_hold = 0.
- Reset mid-word: assert rst after 2 of 4 bytes of word 0 → no mem_we ever, state IDLE, cpu_hold = 1. A fresh start for 1 word then writes addr 0x0 with the new bytes only.
